// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry flop, LSB first; optional subtract via SERIAL_ADDER_SUB_EN.
// Latency: done_out pulses WIDTH cycles after the accepted start edge; one op per WIDTH+1 cycles.
// Backpressure: start_in is honoured only in IDLE (including the done_out cycle); ignored while busy_out=1.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             finish;
  logic             last_bit;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The single full-adder cell working on the current LSBs
  always_comb begin
    bit_s = a_reg[0] ^ b_reg[0] ^ c_reg;
    bit_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
  end

  // Operand selection at load: subtract is a + ~b + 1
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub_in ? ~b_in : b_in;
    c_load = sub_in ? 1'b1 : carry_in;
`else
    b_load = b_in;
    c_load = carry_in;
`endif
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy_out = (state == SHIFT);

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last_bit) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath and result registers; results only move on the final bit
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      done_out <= finish;
      if (load) begin
        a_reg <= a_in;
        b_reg <= b_load;
        c_reg <= c_load;
        cnt   <= '0;
      end
      if (step) begin
        a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
        b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
        res_reg <= {bit_s, res_reg[WIDTH-1:1]};
        c_reg   <= bit_c;
        cnt     <= cnt + CW'(1);
      end
      if (finish) begin
        sum_out   <= {bit_s, res_reg[WIDTH-1:1]};
        carry_out <= bit_c;
      end
    end
  end

endmodule
